// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer, its display driver and the control FSM.
package countdown_timer_pkg;
    localparam int CD_W            = 5;
    localparam int MIN_SEC_DEF     = 5;
    localparam int MAX_SEC_DEF     = 30;
    localparam int DEFAULT_SEC_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } cd_state_e;

    function automatic logic [CD_W-1:0] clamp_sec(input logic [CD_W-1:0] sec,
                                                  input logic [CD_W-1:0] lo,
                                                  input logic [CD_W-1:0] hi);
        if (sec < lo)      return lo;
        else if (sec > hi) return hi;
        else               return sec;
    endfunction
endpackage

// File: rtl/countdown_timer_sec_tick.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt;

    // Tick is the wrap cycle itself so the consumer acts on the same edge the count wraps.
    assign tick = en && (cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/countdown_timer.sv
// Second-resolution countdown with clamped config register and one-cycle expiry pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int MIN_SEC     = MIN_SEC_DEF,
    parameter int MAX_SEC     = MAX_SEC_DEF,
    parameter int DEFAULT_SEC = DEFAULT_SEC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cancel,
    input  logic            pause,
    input  logic            cfg_load,
    input  logic [CD_W-1:0] cfg_sec,
    output logic [CD_W-1:0] cfg_sec_q,
    output logic [CD_W-1:0] countdown_val,
    output logic            countdown_active,
    output logic            timeout
);
    cd_state_e       state, state_nxt;
    logic [CD_W-1:0] val_nxt, cfg_clamped, load_sec;
    logic            timeout_nxt, tick, presc_clr, presc_en;

    assign cfg_clamped = clamp_sec(cfg_sec, CD_W'(MIN_SEC), CD_W'(MAX_SEC));
    // A same-cycle cfg_load feeds the new duration straight into the run.
    assign load_sec    = cfg_load ? cfg_clamped : cfg_sec_q;
    assign presc_clr   = start || cancel || (state != RUN);
    assign presc_en    = (state == RUN) && !pause;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cfg_sec_q <= CD_W'(DEFAULT_SEC);
        else if (cfg_load) cfg_sec_q <= cfg_clamped;
    end

    always_comb begin
        state_nxt   = state;
        val_nxt     = countdown_val;
        timeout_nxt = 1'b0;
        case (state)
            IDLE:   val_nxt = '0;
            RUN: if (tick) begin
                if (countdown_val <= CD_W'(1)) begin
                    val_nxt     = '0;
                    state_nxt   = EXPIRE;
                    timeout_nxt = 1'b1;
                end else begin
                    val_nxt = countdown_val - 1'b1;
                end
            end
            EXPIRE: begin
                state_nxt = IDLE;
                val_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                val_nxt   = '0;
            end
        endcase
        if (start) begin
            state_nxt   = RUN;
            val_nxt     = load_sec;
            timeout_nxt = 1'b0;
        end
        if (cancel) begin
            state_nxt   = IDLE;
            val_nxt     = '0;
            timeout_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            countdown_val    <= '0;
            countdown_active <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            state            <= state_nxt;
            countdown_val    <= val_nxt;
            countdown_active <= (state_nxt != IDLE);
            timeout          <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a remaining-cycles reference model.
module tb_countdown_timer;
    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, cancel = 1'b0, pause = 1'b0, cfg_load = 1'b0;
    logic [4:0] cfg_sec = '0;
    logic [4:0] cfg_sec_q, countdown_val;
    logic       countdown_active, timeout;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cancel          (cancel),
        .pause           (pause),
        .cfg_load        (cfg_load),
        .cfg_sec         (cfg_sec),
        .cfg_sec_q       (cfg_sec_q),
        .countdown_val   (countdown_val),
        .countdown_active(countdown_active),
        .timeout         (timeout)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp_m(input int s);
        if (s < 5)  return 5;
        if (s > 30) return 30;
        return s;
    endfunction

    // Model: a run is "remaining clock cycles until expiry"; shown seconds are its ceiling.
    int m_cfg, m_remain;
    bit m_running, m_expire;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cfg     <= 10;
            m_remain  <= 0;
            m_running <= 1'b0;
            m_expire  <= 1'b0;
        end else begin
            if (cfg_load) m_cfg <= clamp_m(int'(cfg_sec));
            if (cancel) begin
                m_running <= 1'b0;
                m_expire  <= 1'b0;
                m_remain  <= 0;
            end else if (start) begin
                m_running <= 1'b1;
                m_expire  <= 1'b0;
                m_remain  <= (cfg_load ? clamp_m(int'(cfg_sec)) : m_cfg) * TD;
            end else if (m_running) begin
                m_expire <= 1'b0;
                if (!pause) begin
                    m_remain <= m_remain - 1;
                    if (m_remain == 1) begin
                        m_running <= 1'b0;
                        m_expire  <= 1'b1;
                    end
                end
            end else begin
                m_expire <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("model_val", int'(countdown_val), m_running ? (m_remain + TD - 1) / TD : 0);
            check("model_active", int'(countdown_active), int'(m_running || m_expire));
            check("model_timeout", int'(timeout), int'(m_expire));
            check("model_cfg", int'(cfg_sec_q), m_cfg);
        end
    end

    task automatic do_cfg(input int v, input int exp);
        @(negedge clk); cfg_sec = 5'(v); cfg_load = 1'b1;
        @(negedge clk); cfg_load = 1'b0;
        check("cfg_clamp", int'(cfg_sec_q), exp);
    endtask

    // Starts a run and counts cycles after the start edge until timeout is seen.
    task automatic timed_run(input int pause_at, input int pause_len, input int restart_at,
                             input int maxc, output int kto);
        int k;
        kto = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        if (pause_at < 0 && restart_at < 0) check("run_val_k0", int'(countdown_val), 5);
        while (k < maxc) begin
            if (k == pause_at) pause = 1'b1;
            if (k == pause_at + pause_len) pause = 1'b0;
            start = (k == restart_at);
            @(negedge clk);
            k++;
            if (pause_at < 0 && restart_at < 0 && k < 50 && k % 10 == 0)
                check("run_val_step", int'(countdown_val), 5 - k / 10);
            if (timeout) begin
                kto = k;
                break;
            end
        end
        pause = 1'b0;
        start = 1'b0;
        if (kto < 0) check("run_timeout_bound", kto, maxc);
    endtask

    initial begin
        int kto, seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_cfg", int'(cfg_sec_q), 10);
        check("rst_val", int'(countdown_val), 0);
        check("rst_active", int'(countdown_active), 0);
        check("rst_timeout", int'(timeout), 0);

        do_cfg(2, 5);
        do_cfg(31, 30);
        do_cfg(7, 7);
        do_cfg(5, 5);

        timed_run(-1, 0, -1, 200, kto);
        check("full_timeout_cycle", kto, 50);
        @(negedge clk);
        check("full_idle_active", int'(countdown_active), 0);
        check("full_idle_timeout", int'(timeout), 0);

        timed_run(22, 7, -1, 200, kto);
        check("pause_timeout_cycle", kto, 57);
        repeat (2) @(negedge clk);

        timed_run(-1, 0, 35, 200, kto);
        check("restart_timeout_cycle", kto, 86);
        repeat (2) @(negedge clk);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(negedge clk); start = 1'b0; cancel = 1'b0;
        check("cancel_active", int'(countdown_active), 0);
        check("cancel_val", int'(countdown_val), 0);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (timeout) seen++;
        end
        check("cancel_no_timeout", seen, 0);

        @(negedge clk); cfg_sec = 5'd8; cfg_load = 1'b1; start = 1'b1;
        @(negedge clk); cfg_load = 1'b0; start = 1'b0;
        check("cfgstart_val", int'(countdown_val), 8);
        check("cfgstart_cfg", int'(cfg_sec_q), 8);
        check("cfgstart_active", int'(countdown_active), 1);

        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_val", int'(countdown_val), 0);
        check("midrst_active", int'(countdown_active), 0);
        check("midrst_timeout", int'(timeout), 0);
        check("midrst_cfg", int'(cfg_sec_q), 10);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (timeout) seen++;
        end
        check("midrst_no_timeout", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
